// File: rtl/ibex_dummy_instr_reseed_ctrl_pkg.sv
// Shared types and default constants for the dummy-instruction reseed controller.
//   dummy_reseed_state_e : controller state encoding
//   *_DEFAULT            : default parameter values used by the top module
//   reseed_cnt_width()   : width helper for counters that must hold 0..max_val
package ibex_dummy_instr_reseed_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    REQ   = 2'd2,
    LOAD  = 2'd3
  } dummy_reseed_state_e;

  localparam int unsigned RESEED_INTERVAL_DEFAULT    = 256;
  localparam int unsigned ENTROPY_TIMEOUT_DEFAULT    = 1024;
  localparam bit          GATE_DURING_RESEED_DEFAULT = 1'b1;

  // A zero max_val still yields a 1-bit counter so the RTL never declares a
  // zero-width vector when the feature is disabled.
  function automatic int unsigned reseed_cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ibex_dummy_instr_reseed_ctrl.sv
// Dummy-instruction reseed controller.
// Registers the CSR enable/mask for the dummy-instruction inserter, counts
// inserted dummy instructions and, every ReseedInterval insertions, fetches a
// fresh entropy word over a req/ack handshake and loads it into the inserter
// LFSR as a one-cycle seed strobe. CSR-written seeds override automatic loads.
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   csr_dummy_en_i/_mask_i         enable and frequency mask from CSR
//   csr_seed_we_i, csr_seed_i      CSR seed write strobe and value
//   insert_dummy_instr_i           inserter issued a dummy instruction
//   entropy_req_o/_ack_i/_data_i   entropy handshake
//   dummy_instr_en_o/_mask_o       registered config to the inserter
//   dummy_instr_seed_en_o/_seed_o  seed load strobe and value
//   reseed_busy_o                  reseed in progress (REQ or LOAD)
//   entropy_err_o                  sticky entropy timeout flag
//
// state | meaning
// IDLE  | disabled, insertion counter frozen
// COUNT | enabled, counting inserted dummy instructions
// REQ   | entropy request outstanding, waiting for ack or timeout
// LOAD  | entropy captured, seed strobe issued on the following cycle
module ibex_dummy_instr_reseed_ctrl
  import ibex_dummy_instr_reseed_ctrl_pkg::*;
#(
  parameter int unsigned ReseedInterval   = RESEED_INTERVAL_DEFAULT,
  parameter int unsigned EntropyTimeout   = ENTROPY_TIMEOUT_DEFAULT,
  parameter bit          GateDuringReseed = GATE_DURING_RESEED_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        csr_dummy_en_i,
  input  logic [2:0]  csr_dummy_mask_i,
  input  logic        csr_seed_we_i,
  input  logic [31:0] csr_seed_i,
  input  logic        insert_dummy_instr_i,
  output logic        entropy_req_o,
  input  logic        entropy_ack_i,
  input  logic [31:0] entropy_data_i,
  output logic        dummy_instr_en_o,
  output logic [2:0]  dummy_instr_mask_o,
  output logic        dummy_instr_seed_en_o,
  output logic [31:0] dummy_instr_seed_o,
  output logic        reseed_busy_o,
  output logic        entropy_err_o
);

  localparam int unsigned CntW = reseed_cnt_width(ReseedInterval);
  localparam int unsigned TmoW = reseed_cnt_width(EntropyTimeout);
  localparam logic [CntW-1:0] CntLast = CntW'(ReseedInterval - 1);
  // Timeout runs as a down-counter preloaded while outside REQ, so REQ lasts
  // exactly EntropyTimeout cycles when no ack arrives.
  localparam logic [TmoW-1:0] TmoLoad = TmoW'(EntropyTimeout - 1);
  localparam bit ReseedOn  = (ReseedInterval != 0);
  localparam bit TimeoutOn = (EntropyTimeout != 0);

  dummy_reseed_state_e state_q, state_d;
  logic [CntW-1:0]     ins_cnt_q, ins_cnt_d;
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [31:0]         entropy_q, entropy_d;
  logic                timeout;

  always_comb begin
    state_d   = state_q;
    ins_cnt_d = ins_cnt_q;
    tmo_cnt_d = TmoLoad;
    entropy_d = entropy_q;
    timeout   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (csr_dummy_en_i) state_d = COUNT;
      end
      COUNT: begin
        // Disable wins over a same-cycle insertion; the count is kept.
        if (!csr_dummy_en_i) begin
          state_d = IDLE;
        end else if (insert_dummy_instr_i) begin
          if (ReseedOn && (ins_cnt_q == CntLast)) begin
            ins_cnt_d = '0;
            state_d   = REQ;
          end else begin
            ins_cnt_d = ins_cnt_q + CntW'(1);
          end
        end
      end
      REQ: begin
        // Ack is checked first so it beats a same-cycle timeout.
        if (entropy_ack_i) begin
          entropy_d = entropy_data_i;
          state_d   = LOAD;
        end else if (TimeoutOn && (tmo_cnt_q == '0)) begin
          timeout = 1'b1;
          state_d = csr_dummy_en_i ? COUNT : IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - TmoW'(1);
        end
      end
      LOAD: begin
        state_d = csr_dummy_en_i ? COUNT : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (csr_seed_we_i) ins_cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q               <= IDLE;
      ins_cnt_q             <= '0;
      tmo_cnt_q             <= '0;
      entropy_q             <= '0;
      entropy_req_o         <= 1'b0;
      reseed_busy_o         <= 1'b0;
      dummy_instr_en_o      <= 1'b0;
      dummy_instr_mask_o    <= '0;
      dummy_instr_seed_en_o <= 1'b0;
      dummy_instr_seed_o    <= '0;
      entropy_err_o         <= 1'b0;
    end else begin
      state_q            <= state_d;
      ins_cnt_q          <= ins_cnt_d;
      tmo_cnt_q          <= tmo_cnt_d;
      entropy_q          <= entropy_d;
      entropy_req_o      <= (state_d == REQ);
      reseed_busy_o      <= (state_d == REQ) || (state_d == LOAD);
      dummy_instr_en_o   <= csr_dummy_en_i && !(GateDuringReseed && (state_d == REQ));
      dummy_instr_mask_o <= csr_dummy_mask_i;
      // A CSR write during LOAD merges into the same strobe and replaces the
      // entropy word, so the inserter only ever sees one load.
      dummy_instr_seed_en_o <= csr_seed_we_i || (state_q == LOAD);
      if (csr_seed_we_i) begin
        dummy_instr_seed_o <= csr_seed_i;
      end else if (state_q == LOAD) begin
        dummy_instr_seed_o <= entropy_q;
      end
      entropy_err_o <= entropy_err_o | timeout;
    end
  end

endmodule

// File: tb/tb_ibex_dummy_instr_reseed_ctrl.sv
module tb_ibex_dummy_instr_reseed_ctrl;

  localparam int unsigned RI = 4;
  localparam int unsigned ET = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        csr_dummy_en_i = 1'b0;
  logic [2:0]  csr_dummy_mask_i = '0;
  logic        csr_seed_we_i = 1'b0;
  logic [31:0] csr_seed_i = '0;
  logic        insert_dummy_instr_i = 1'b0;
  logic        entropy_ack_i = 1'b0;
  logic [31:0] entropy_data_i = '0;

  logic        entropy_req_o, dummy_instr_en_o, dummy_instr_seed_en_o;
  logic        reseed_busy_o, entropy_err_o;
  logic [2:0]  dummy_instr_mask_o;
  logic [31:0] dummy_instr_seed_o;

  logic        z_req, z_en, z_seed_en, z_busy, z_err;
  logic [2:0]  z_mask;
  logic [31:0] z_seed;

  ibex_dummy_instr_reseed_ctrl #(
    .ReseedInterval(RI), .EntropyTimeout(ET), .GateDuringReseed(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .csr_dummy_en_i(csr_dummy_en_i), .csr_dummy_mask_i(csr_dummy_mask_i),
    .csr_seed_we_i(csr_seed_we_i), .csr_seed_i(csr_seed_i),
    .insert_dummy_instr_i(insert_dummy_instr_i),
    .entropy_req_o(entropy_req_o), .entropy_ack_i(entropy_ack_i),
    .entropy_data_i(entropy_data_i),
    .dummy_instr_en_o(dummy_instr_en_o), .dummy_instr_mask_o(dummy_instr_mask_o),
    .dummy_instr_seed_en_o(dummy_instr_seed_en_o), .dummy_instr_seed_o(dummy_instr_seed_o),
    .reseed_busy_o(reseed_busy_o), .entropy_err_o(entropy_err_o)
  );

  // Automatic reseed disabled: must never request entropy.
  ibex_dummy_instr_reseed_ctrl #(
    .ReseedInterval(0), .EntropyTimeout(ET), .GateDuringReseed(1'b1)
  ) dut_noreseed (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .csr_dummy_en_i(csr_dummy_en_i), .csr_dummy_mask_i(csr_dummy_mask_i),
    .csr_seed_we_i(csr_seed_we_i), .csr_seed_i(csr_seed_i),
    .insert_dummy_instr_i(insert_dummy_instr_i),
    .entropy_req_o(z_req), .entropy_ack_i(entropy_ack_i),
    .entropy_data_i(entropy_data_i),
    .dummy_instr_en_o(z_en), .dummy_instr_mask_o(z_mask),
    .dummy_instr_seed_en_o(z_seed_en), .dummy_instr_seed_o(z_seed),
    .reseed_busy_o(z_busy), .entropy_err_o(z_err)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    longint   cyc;
    bit       req;
    bit       en;
    bit [2:0] mask;
    bit       seed_en;
    bit       busy;
    bit       err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] seed_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  longint      edge_cnt = 0;
  int          z_req_hits = 0;
  int          z_inserts = 0;

  // Reference model: how far through the insertion interval we are, whether
  // an entropy request is open and for how long, and whether a captured word
  // is waiting to be handed to the inserter.
  bit          m_active, m_waiting, m_loading, m_err;
  int          m_inserts, m_waited;
  logic [31:0] m_word;

  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) void'(exp_q.pop_front());
      if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
        mon_e = exp_q.pop_front();
        check("req", entropy_req_o, mon_e.req);
        check("en", dummy_instr_en_o, mon_e.en);
        check("mask", dummy_instr_mask_o, mon_e.mask);
        check("seed_en", dummy_instr_seed_en_o, mon_e.seed_en);
        check("busy", reseed_busy_o, mon_e.busy);
        check("err", entropy_err_o, mon_e.err);
      end
      if (dummy_instr_seed_en_o === 1'b1) begin
        if (seed_q.size() == 0) check("seed_unexpected", 1, 0);
        else check("seed_val", dummy_instr_seed_o, seed_q.pop_front());
      end
      if (z_req !== 1'b0) z_req_hits++;
    end
  end

  task automatic model_clear();
    m_active = 0; m_waiting = 0; m_loading = 0; m_err = 0;
    m_inserts = 0; m_waited = 0; m_word = '0;
  endtask

  task automatic step(input bit en, input bit [2:0] mask, input bit we,
                      input logic [31:0] sd, input bit ins, input bit ack,
                      input logic [31:0] data);
    exp_t e;
    @(posedge clk_i);
    #1;
    csr_dummy_en_i = en; csr_dummy_mask_i = mask; csr_seed_we_i = we;
    csr_seed_i = sd; insert_dummy_instr_i = ins; entropy_ack_i = ack;
    entropy_data_i = data;
    if (ins) z_inserts++;

    e.seed_en = m_loading || we;
    if (e.seed_en) seed_q.push_back(we ? sd : m_word);

    if (m_loading) begin
      m_loading = 0;
      m_active = en;
    end else if (m_waiting) begin
      if (ack) begin
        m_word = data; m_waiting = 0; m_loading = 1;
      end else if (ET != 0 && m_waited + 1 == ET) begin
        m_err = 1; m_waiting = 0; m_active = en;
      end else begin
        m_waited++;
      end
    end else if (m_active) begin
      if (!en) m_active = 0;
      else if (ins) begin
        if (RI != 0 && m_inserts + 1 == RI) begin
          m_inserts = 0; m_waiting = 1; m_waited = 0;
        end else begin
          m_inserts++;
        end
      end
    end else if (en) begin
      m_active = 1;
    end
    if (we) m_inserts = 0;

    e.cyc  = edge_cnt + 1;
    e.req  = m_waiting;
    e.busy = m_waiting || m_loading;
    e.en   = en && !m_waiting;
    e.mask = mask;
    e.err  = m_err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit en, input int n);
    for (int i = 0; i < n; i++) step(en, 3'b010, 0, '0, 0, 0, '0);
  endtask

  task automatic inserts(input int n);
    for (int i = 0; i < n; i++) step(1, 3'b010, 0, '0, 1, 0, '0);
  endtask

  // Reset asserted mid-cycle; outputs must drop without waiting for a clock.
  task automatic do_reset();
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check("rst_req", entropy_req_o, 0);
    check("rst_en", dummy_instr_en_o, 0);
    check("rst_mask", dummy_instr_mask_o, 0);
    check("rst_seed_en", dummy_instr_seed_en_o, 0);
    check("rst_seed", dummy_instr_seed_o, 0);
    check("rst_busy", reseed_busy_o, 0);
    check("rst_err", entropy_err_o, 0);
    exp_q.delete();
    seed_q.delete();
    model_clear();
    csr_dummy_en_i = 0; csr_dummy_mask_i = '0; csr_seed_we_i = 0; csr_seed_i = '0;
    insert_dummy_instr_i = 0; entropy_ack_i = 0; entropy_data_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk_i);
    do_reset();

    // Interval reseed with ack two cycles after req.
    idle(1, 1);
    inserts(RI);
    idle(1, 2);
    step(1, 3'b010, 0, '0, 0, 1, 32'hA5A5_0F0F);
    idle(1, 3);
    inserts(RI - 1);
    idle(1, 2);

    // Timeout: no ack.
    inserts(1);
    idle(1, ET + 4);

    // CSR seed write colliding with the LOAD cycle.
    inserts(RI);
    step(1, 3'b010, 0, '0, 0, 1, 32'hDEAD_BEEF);
    step(1, 3'b010, 1, 32'h1234_5678, 0, 0, '0);
    idle(1, 3);

    // Disable while the request is open.
    inserts(RI);
    idle(0, 3);
    step(0, 3'b010, 0, '0, 0, 1, 32'h0BAD_F00D);
    idle(0, 4);

    // Mask latency.
    step(1, 3'b000, 0, '0, 0, 0, '0);
    step(1, 3'b101, 0, '0, 0, 0, '0);
    step(1, 3'b101, 0, '0, 0, 0, '0);

    // Reset in REQ, then a late ack.
    inserts(RI);
    idle(1, 2);
    do_reset();
    step(0, 3'b000, 0, '0, 0, 1, 32'h5555_AAAA);
    idle(0, 3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 15) != 0, 3'($urandom_range(0, 7)),
           $urandom_range(0, 30) == 0, $urandom(), $urandom_range(0, 1) == 1,
           $urandom_range(0, 4) == 0, $urandom());
    end
    idle(1, 4);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);

    check("seed_queue_drained", seed_q.size(), 0);
    check("noreseed_req_never", z_req_hits, 0);
    check("noreseed_enough_inserts", z_inserts >= 1000, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
